// File: rtl/display_pkg.sv
// display_pkg: shared types, constants and helpers for the display scan block
package display_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

    typedef logic [3:0] bcd_nib_t;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle
// Ports: clk, rst_n (async active-low), start (load bin_in when idle),
//        bin_in (binary value), busy (iterating), done (pulse on the final
//        iteration cycle; bcd_out is final from the next cycle), bcd_out.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*N_DIGITS-1:0]   bcd_out
);

    localparam int DW = 4 * N_DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [DW-1:0]    acc_q, acc_d, adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < N_DIGITS; i++)
            adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
        done   = busy_q && cnt_q == CW'(BIN_W - 1);
        bin_d  = bin_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start && !busy_q) begin
            bin_d  = bin_in;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // the top adjusted bit falls off; an overflowed value is blanked anyway
            {acc_d, bin_d} = {adj[DW-2:0], bin_q, 1'b0};
            cnt_d  = cnt_q + CW'(1);
            busy_d = !done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign bcd_out = acc_q;

endmodule

// File: rtl/display_scan.sv
// display_scan: accepts binary values, converts to BCD and scans them onto a multiplexed digit bus
// Ports: clk, rst_n (async active-low), in_valid/in_data/in_ready (value handshake),
//        data (digit code, 4'hF = blank), digit_en (one-hot position enable),
//        ovf (last committed value did not fit in N_DIGITS digits).
module display_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [BIN_W-1:0]    in_data,
    output logic                in_ready,
    output logic [3:0]          data,
    output logic [N_DIGITS-1:0] digit_en,
    output logic                ovf
);

    localparam int DW = 4 * N_DIGITS;
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam longint unsigned LIMIT = pow10(N_DIGITS) - 1;

    state_e              state_q, state_d;
    logic [DW-1:0]       disp_q, disp_d;
    logic                ovf_q, ovf_d;
    logic                pend_q, pend_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_DIGITS-1:0] en_q, en_d;
    logic                start, busy, done, tc, lz;
    logic [DW-1:0]       bcd_out;
    bcd_nib_t            nib;

    bin2bcd_seq #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (in_data),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    always_comb begin
        in_ready = state_q == IDLE && !busy;
        start    = in_valid && in_ready;
        state_d  = state_q;
        disp_d   = disp_q;
        ovf_d    = ovf_q;
        pend_d   = pend_q;
        if (start) begin
            state_d = CONV;
            pend_d  = 64'(in_data) > LIMIT;
        end
        if (state_q == CONV && done) state_d = COMMIT;
        if (state_q == COMMIT) begin
            state_d = IDLE;
            disp_d  = bcd_out;
            ovf_d   = pend_q;
        end
    end

    always_comb begin
        tc    = cnt_q == CW'(SCAN_DIV - 1);
        cnt_d = tc ? '0 : cnt_q + CW'(1);
        idx_d = !tc ? idx_q : idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + IW'(1);
        en_d  = N_DIGITS'(1) << idx_d;
    end

    // a position is a leading zero when it and every more significant digit are zero
    always_comb begin
        lz  = BLANK_LZ != 0 && idx_q != '0;
        nib = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'h0) lz = 1'b0;
            if (i == int'(idx_q)) nib = disp_q[4*i +: 4];
        end
        data = ovf_q || lz ? BLANK_CODE : nib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            en_q    <= N_DIGITS'(1);
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
        end
    end

    assign digit_en = en_q;
    assign ovf      = ovf_q;

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Upstream feeder for the 7-segment decoder, which takes a 4-bit digit code and blanks any code >= 10.
- Accepts a binary value over a valid/ready handshake and converts it to BCD sequentially with shift-add-3.
- Time-multiplexes the BCD digits onto one shared 4-bit digit bus, with a one-hot digit-enable per display position.
- Blanks leading zeros and overflowed values by driving code 4'hF.

Parameters:
- N_DIGITS, 4, number of display positions; digit 0 is least significant.
- BIN_W, 14, width of the binary input.
- SCAN_DIV, 50000, clock cycles each digit is enabled per refresh (>= 2).
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show them.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_data  in  BIN_W  unsigned value to display.
- in_ready  out  1  block can accept a value.
- data  out  4  digit code to the decoder; 4'hF = blank.
- digit_en  out  N_DIGITS  one-hot, active-high position enable.
- ovf  out  1  last committed value exceeded 10^N_DIGITS-1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While asserted:
  - state=IDLE; in_ready=1; displayed BCD register = 0; ovf=0.
  - digit index=0, so digit_en=...0001 and data=4'h0 (units digit never blanked).
  - scan counter=0.
- FSM states IDLE, CONV, COMMIT.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data and clear the BCD accumulator. Latch ovf_pend = (in_data > 10^N_DIGITS-1). Go to CONV.
  - CONV: in_ready=0. Run exactly BIN_W iterations, one per cycle. Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd,bin} left by 1. After the BIN_W-th iteration, go to COMMIT.
  - COMMIT: in_ready=0. Copy the accumulator into the displayed BCD register and ovf_pend into ovf. Return to IDLE.
- Latency: value accepted at edge T is displayed from edge T+BIN_W+1; in_ready rises again at the same edge.
- in_valid while in_ready=0 is ignored, not queued.
- The displayed value holds its old contents during CONV; no partial BCD is ever visible.
- Accumulator width is 4*N_DIGITS. Bits shifted out the top on overflow are discarded; this is harmless because ovf forces full blanking.
- Scan timing:
  - The counter runs 0..SCAN_DIV-1 continuously, independent of the FSM.
  - At terminal count, the counter resets to 0 and the digit index advances by 1, wrapping N_DIGITS-1 -> 0.
  - digit_en is registered, one-hot of the index, and exactly one bit is always high.
- data is combinational from the index, the displayed register and ovf, in this priority:
  - if ovf=1: 4'hF on every digit.
  - else if BLANK_LZ and index>0 and all displayed digits from index up to N_DIGITS-1 are 0: 4'hF.
  - else: the displayed BCD nibble at index.
- A commit landing on the same edge as an index advance is legal; the new index and new value appear together.
- Reset mid-CONV or mid-COMMIT: the conversion is abandoned, all state returns to reset values, and nothing is committed.

Decomposition:
- Package display_pkg holds:
  - BLANK_CODE = 4'hF;
  - the state enum {IDLE, CONV, COMMIT};
  - a function pow10(n) for the overflow limit;
  - the BCD nibble type logic [3:0].
- Sub-module bin2bcd_seq holds the accumulator and iteration counter and performs the shift-add-3 conversion.
  - Interface: start, bin_in, busy, done (one-cycle pulse), bcd_out.
- display_scan holds the handshake FSM, displayed register, ovf, scan counter, digit index and output muxing.

Test Plan:
- Reset, SCAN_DIV=4, N_DIGITS=4: digit_en=0001, data=0, ovf=0, in_ready=1. The index advances every 4 cycles, 0001->0010->0100->1000->0001. data=0 on digit 0 and 4'hF on digits 1-3.
- Load 1234, BIN_W=14: in_ready is low for exactly 15 cycles. Afterwards digits 0..3 show 4,3,2,1 and ovf=0.
- Load 7 with BLANK_LZ=1: digit 0 shows 7, digits 1-3 show 4'hF. Load 1005: digits show 5,0,0,1 (inner zeros not blanked). Repeat 7 with BLANK_LZ=0: digits show 7,0,0,0.
- Load 10000 (exceeds 9999): after commit ovf=1 and data=4'hF on all digits. Then load 9999: ovf=0 and all digits show 9.
- Pulse in_valid with 42 during CONV of 1234: no handshake occurs. The display shows 1234 and 42 never appears.
- Assert rst_n=0 at cycle 5 of a conversion of 8888: the display returns to 0, ovf=0, in_ready=1. No 8888 ever appears after reset is released.
